// File: rtl/quiz_pkg.sv
// Shared quiz-system definitions: round states, player-count decode and player constants.
// Used by the arbiter, scoring and display stages.
package quiz_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int NUM_PLAYERS = 4;

   localparam logic [3:0] PLAYER_ONEHOT [NUM_PLAYERS] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   // Enabled-player mask indexed by {select2, select1}
   localparam logic [3:0] PLAYER_MASK [4] = '{4'b1111, 4'b0011, 4'b0111, 4'b1111};

   // Lowest-numbered player among simultaneous presses wins
   function automatic logic [3:0] lowest_player(input logic [3:0] v);
      lowest_player = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (v[i]) lowest_player = PLAYER_ONEHOT[i];
      end
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for one raw asynchronous input plus rising-edge detect.
// The rise flag is high during the second cycle after the input is first sampled high.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/answer_arbiter.sv
// Quiz buzzer arbiter: locks the first valid answerer, runs the answer window timer,
// tracks early-press fouls and issues the host verdict pulses.
module answer_arbiter
   import quiz_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int ANSWER_SEC = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] btn,
   input  logic       judge_yes,
   input  logic       judge_no,
   input  logic       select1,
   input  logic       select2,
   output logic [3:0] answer,
   output logic       getter,
   output logic       Yes,
   output logic       No,
   output logic [3:0] timer_sec,
   output logic       timeout,
   output logic [3:0] foul
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [3:0] SEC_LOAD = 4'(ANSWER_SEC);

   state_t        state;
   logic [PW-1:0] presc;
   logic          start_rise;
   logic          yes_rise;
   logic          no_rise;
   logic [3:0]    btn_rise;
   logic [3:0]    press;
   logic [3:0]    valid;
   logic          tick;
   logic          expire;

   edge_sync u_start (.clk(clk), .rst(rst), .din(start),     .rise(start_rise));
   edge_sync u_yes   (.clk(clk), .rst(rst), .din(judge_yes), .rise(yes_rise));
   edge_sync u_no    (.clk(clk), .rst(rst), .din(judge_no),  .rise(no_rise));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_btn
         edge_sync u_btn (.clk(clk), .rst(rst), .din(btn[gi]), .rise(btn_rise[gi]));
      end
   endgenerate

   assign press  = btn_rise & PLAYER_MASK[{select2, select1}];
   assign valid  = press & ~foul;
   assign tick   = (presc == PRESC_MAX);
   assign expire = tick && (timer_sec <= 4'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         answer    <= '0;
         getter    <= 1'b0;
         Yes       <= 1'b0;
         No        <= 1'b0;
         timeout   <= 1'b0;
         timer_sec <= '0;
         foul      <= '0;
         presc     <= '0;
      end else begin
         getter  <= 1'b0;
         Yes     <= 1'b0;
         No      <= 1'b0;
         timeout <= 1'b0;
         if (start_rise) begin
            // New question from any state; an abort gives no verdict
            state     <= ARMED;
            getter    <= 1'b1;
            answer    <= '0;
            timer_sec <= SEC_LOAD;
            presc     <= '0;
            // Fouls made while waiting carry into this round; a resolved round wipes them
            case (state)
               IDLE:    foul <= foul | press;
               DONE:    foul <= '0;
               default: ;
            endcase
         end else begin
            case (state)
               IDLE: foul <= foul | press;
               ARMED: begin
                  if (|valid) begin
                     state     <= LOCKED;
                     answer    <= lowest_player(valid);
                     timer_sec <= SEC_LOAD;
                     presc     <= '0;
                  end else if (tick) begin
                     presc <= '0;
                     if (expire) begin
                        timer_sec <= '0;
                        timeout   <= 1'b1;
                        answer    <= '0;
                        state     <= IDLE;
                     end else begin
                        timer_sec <= timer_sec - 4'd1;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               LOCKED: begin
                  // Conflicting verdicts in one cycle are both dropped
                  if (yes_rise ^ no_rise) begin
                     Yes   <= yes_rise;
                     No    <= no_rise;
                     state <= DONE;
                  end else if (tick) begin
                     presc <= '0;
                     if (expire) begin
                        timer_sec <= '0;
                        No        <= 1'b1;
                        state     <= DONE;
                     end else begin
                        timer_sec <= timer_sec - 4'd1;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               DONE: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_answer_arbiter.sv
// Self-checking bench for answer_arbiter (CLK_HZ=10, ANSWER_SEC=3): vector table with a
// scoreboard queue, plus hand-written window-expiry and reset sequences.
module tb_answer_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] btn;
   logic       judge_yes;
   logic       judge_no;
   logic       select1;
   logic       select2;
   logic [3:0] answer;
   logic       getter;
   logic       Yes;
   logic       No;
   logic [3:0] timer_sec;
   logic       timeout;
   logic [3:0] foul;

   answer_arbiter #(.CLK_HZ(10), .ANSWER_SEC(3)) dut (
      .clk(clk), .rst(rst), .start(start), .btn(btn),
      .judge_yes(judge_yes), .judge_no(judge_no),
      .select1(select1), .select2(select2),
      .answer(answer), .getter(getter), .Yes(Yes), .No(No),
      .timer_sec(timer_sec), .timeout(timeout), .foul(foul)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       start;
      logic [3:0] btn;
      logic       jy;
      logic       jn;
      logic [1:0] sel;
      logic [3:0] ans;
      logic [3:0] tmr;
      logic [3:0] foul;
      int         g;
      int         y;
      int         n;
      int         t;
   } vec_t;

   typedef struct {
      string      name;
      logic [3:0] ans;
      logic [3:0] tmr;
      logic [3:0] foul;
      int         g;
      int         y;
      int         n;
      int         t;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[22];

   int checks = 0;
   int passed = 0;

   // Free-running pulse totals and pulse-rule violations, sampled on the falling edge
   int   getter_tot = 0;
   int   yes_tot = 0;
   int   no_tot = 0;
   int   tout_tot = 0;
   int   viol = 0;
   logic pg = 1'b0;
   logic py = 1'b0;
   logic pn = 1'b0;
   logic pt = 1'b0;

   always @(negedge clk) begin
      if (getter)  getter_tot++;
      if (Yes)     yes_tot++;
      if (No)      no_tot++;
      if (timeout) tout_tot++;
      if ((getter && pg) || (Yes && py) || (No && pn) || (timeout && pt) || (Yes && No)) viol++;
      pg = getter;
      py = Yes;
      pn = No;
      pt = timeout;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic vec_t mk(input string name, input logic s, input logic [3:0] b,
                               input logic jy, input logic jn, input logic [1:0] sel,
                               input logic [3:0] ans, input logic [3:0] tmr, input logic [3:0] fl,
                               input int g, input int y, input int n, input int t);
      vec_t v;
      v.name = name; v.start = s; v.btn = b; v.jy = jy; v.jn = jn; v.sel = sel;
      v.ans = ans; v.tmr = tmr; v.foul = fl; v.g = g; v.y = y; v.n = n; v.t = t;
      return v;
   endfunction

   // Drive one stimulus for 3 cycles (synchronizer latency), sample, release, count pulses
   task automatic apply(input vec_t v);
      exp_t       e;
      int         g0, y0, n0, t0;
      logic [3:0] a, tm, f;
      e.name = v.name; e.ans = v.ans; e.tmr = v.tmr; e.foul = v.foul;
      e.g = v.g; e.y = v.y; e.n = v.n; e.t = v.t;
      sb.push_back(e);
      g0 = getter_tot; y0 = yes_tot; n0 = no_tot; t0 = tout_tot;
      start = v.start; btn = v.btn; judge_yes = v.jy; judge_no = v.jn;
      {select2, select1} = v.sel;
      repeat (3) tick();
      a = answer; tm = timer_sec; f = foul;
      start = 1'b0; btn = '0; judge_yes = 1'b0; judge_no = 1'b0;
      tick();
      e = sb.pop_front();
      check({e.name, ".answer"},  32'(a),  32'(e.ans));
      check({e.name, ".timer"},   32'(tm), 32'(e.tmr));
      check({e.name, ".foul"},    32'(f),  32'(e.foul));
      check({e.name, ".getter"},  getter_tot - g0, e.g);
      check({e.name, ".yes"},     yes_tot - y0,    e.y);
      check({e.name, ".no"},      no_tot - n0,     e.n);
      check({e.name, ".timeout"}, tout_tot - t0,   e.t);
      $display("vec %-14s answer=%b timer=%0d foul=%b getter=%0d yes=%0d no=%0d timeout=%0d",
               e.name, a, tm, f, getter_tot - g0, yes_tot - y0, no_tot - n0, tout_tot - t0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] seq;
      logic [3:0]  prev_t;
      int          at;
      int          c0, c1;

      //                name          st  btn      jy jn sel    ans      tmr foul     g y n t
      vecs[0]  = mk("idle_foul0",    0, 4'b0001, 0, 0, 2'b00, 4'b0000, 0, 4'b0001, 0,0,0,0);
      vecs[1]  = mk("start_f",       1, 4'b0000, 0, 0, 2'b00, 4'b0000, 3, 4'b0001, 1,0,0,0);
      vecs[2]  = mk("fouled_btn0",   0, 4'b0001, 0, 0, 2'b00, 4'b0000, 3, 4'b0001, 0,0,0,0);
      vecs[3]  = mk("btn3_lock",     0, 4'b1000, 0, 0, 2'b00, 4'b1000, 3, 4'b0001, 0,0,0,0);
      vecs[4]  = mk("yes_f",         0, 4'b0000, 1, 0, 2'b00, 4'b1000, 3, 4'b0001, 0,1,0,0);
      vecs[5]  = mk("start_clr",     1, 4'b0000, 0, 0, 2'b00, 4'b0000, 3, 4'b0000, 1,0,0,0);
      vecs[6]  = mk("btn0100",       0, 4'b0100, 0, 0, 2'b00, 4'b0100, 3, 4'b0000, 0,0,0,0);
      vecs[7]  = mk("yes_a",         0, 4'b0000, 1, 0, 2'b00, 4'b0100, 3, 4'b0000, 0,1,0,0);
      vecs[8]  = mk("start_b",       1, 4'b0000, 0, 0, 2'b00, 4'b0000, 3, 4'b0000, 1,0,0,0);
      vecs[9]  = mk("btn0110",       0, 4'b0110, 0, 0, 2'b00, 4'b0010, 3, 4'b0000, 0,0,0,0);
      vecs[10] = mk("yes_b",         0, 4'b0000, 1, 0, 2'b00, 4'b0010, 3, 4'b0000, 0,1,0,0);
      vecs[11] = mk("done_btn",      0, 4'b0001, 0, 0, 2'b00, 4'b0010, 3, 4'b0000, 0,0,0,0);
      vecs[12] = mk("start_2p",      1, 4'b0000, 0, 0, 2'b01, 4'b0000, 3, 4'b0000, 1,0,0,0);
      vecs[13] = mk("btn1000_dis",   0, 4'b1000, 0, 0, 2'b01, 4'b0000, 3, 4'b0000, 0,0,0,0);
      vecs[14] = mk("btn0010_2p",    0, 4'b0010, 0, 0, 2'b01, 4'b0010, 3, 4'b0000, 0,0,0,0);
      vecs[15] = mk("judge_both",    0, 4'b0000, 1, 1, 2'b01, 4'b0010, 3, 4'b0000, 0,0,0,0);
      vecs[16] = mk("no_2p",         0, 4'b0000, 0, 1, 2'b01, 4'b0010, 3, 4'b0000, 0,0,1,0);
      vecs[17] = mk("start_3p",      1, 4'b0000, 0, 0, 2'b10, 4'b0000, 3, 4'b0000, 1,0,0,0);
      vecs[18] = mk("btn1100_3p",    0, 4'b1100, 0, 0, 2'b10, 4'b0100, 3, 4'b0000, 0,0,0,0);
      vecs[19] = mk("abort_locked",  1, 4'b0000, 0, 0, 2'b10, 4'b0000, 3, 4'b0000, 1,0,0,0);
      vecs[20] = mk("btn0001",       0, 4'b0001, 0, 0, 2'b00, 4'b0001, 3, 4'b0000, 0,0,0,0);
      vecs[21] = mk("no_c",          0, 4'b0000, 0, 1, 2'b00, 4'b0001, 3, 4'b0000, 0,0,1,0);

      rst = 1'b0; start = 1'b0; btn = '0; judge_yes = 1'b0; judge_no = 1'b0;
      select1 = 1'b0; select2 = 1'b0;
      repeat (3) tick();
      check("rst.answer", 32'(answer), 0);
      check("rst.timer",  32'(timer_sec), 0);
      check("rst.foul",   32'(foul), 0);
      check("rst.pulses", 32'({getter, Yes, No, timeout}), 0);
      rst = 1'b1;
      tick();

      // Unanswered window: 3,2,1,0 one second (10 clk) apart, then a timeout pulse
      apply(mk("to_start", 1, 4'b0000, 0, 0, 2'b00, 4'b0000, 3, 4'b0000, 1,0,0,0));
      seq = {12'h000, timer_sec};
      prev_t = timer_sec;
      at = -1;
      c0 = tout_tot;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (timer_sec != prev_t) begin
            seq = {seq[11:0], timer_sec};
            prev_t = timer_sec;
         end
         if (timeout && at < 0) at = n;
      end
      check("to.sequence", 32'(seq), 32'h3210);
      check("to.cycle",    at, 29);
      check("to.pulses",   tout_tot - c0, 1);
      check("to.answer",   32'(answer), 0);
      $display("seq timeout      timer_seq=%h at=%0d", seq, at);

      foreach (vecs[i]) apply(vecs[i]);

      // Locked with no verdict: window expiry counts as wrong
      apply(mk("lt_start", 1, 4'b0000, 0, 0, 2'b00, 4'b0000, 3, 4'b0000, 1,0,0,0));
      apply(mk("lt_btn0",  0, 4'b0001, 0, 0, 2'b00, 4'b0001, 3, 4'b0000, 0,0,0,0));
      at = -1;
      c0 = no_tot;
      c1 = yes_tot;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (No && at < 0) at = n;
      end
      check("lt.cycle",  at, 29);
      check("lt.no",     no_tot - c0, 1);
      check("lt.yes",    yes_tot - c1, 0);
      check("lt.answer", 32'(answer), 32'b0001);
      check("lt.timer",  32'(timer_sec), 0);
      $display("seq locked_expiry no_at=%0d answer=%b", at, answer);

      // Reset while locked with a verdict in flight
      apply(mk("rs_start", 1, 4'b0000, 0, 0, 2'b00, 4'b0000, 3, 4'b0000, 1,0,0,0));
      apply(mk("rs_btn2",  0, 4'b0100, 0, 0, 2'b00, 4'b0100, 3, 4'b0000, 0,0,0,0));
      judge_yes = 1'b1;
      tick();
      #3 rst = 1'b0;
      #1;
      check("rs.answer", 32'(answer), 0);
      check("rs.timer",  32'(timer_sec), 0);
      check("rs.pulses", 32'({getter, Yes, No, timeout}), 0);
      c0 = yes_tot;
      c1 = no_tot;
      repeat (2) tick();
      #2 rst = 1'b1;
      repeat (10) tick();
      judge_yes = 1'b0;
      tick();
      check("rs.verdicts", (yes_tot - c0) + (no_tot - c1), 0);
      $display("seq reset_locked answer=%b verdicts=%0d", answer, (yes_tot - c0) + (no_tot - c1));
      apply(mk("rs_idle_foul", 0, 4'b0001, 0, 0, 2'b00, 4'b0000, 0, 4'b0001, 0,0,0,0));

      check("pulse_rules", viol, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/answer_arbiter.md
ANSWER_ARBITER -- requirements
Module: answer_arbiter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter ANSWER_SEC, default 9, answer window length in seconds (1..15).
REQ-003 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: start  in  1  host "new question" button, raw asynchronous.
REQ-006 SHALL have ports: btn  in  4  player buzzer buttons, bit i = player i+1, raw asynchronous.
REQ-007 SHALL have ports: judge_yes / judge_no  in  1 each  host verdict buttons, raw asynchronous.
REQ-008 SHALL have ports: select1, select2  in  1 each  player-count selection.
REQ-009 SHALL have ports: answer  out  4  one-hot locked answerer, 0 = none.
REQ-010 SHALL have ports: getter  out  1  one-cycle pulse at each round start.
REQ-011 SHALL have ports: Yes / No  out  1 each  one-cycle verdict pulses.
REQ-012 SHALL have ports: timer_sec  out  4  remaining seconds, binary.
REQ-013 SHALL have ports: timeout  out  1  one-cycle pulse when ARMED window expires.
REQ-014 SHALL have ports: foul  out  4  sticky early-press flags, bit per player.

Function
REQ-015 All raw inputs SHALL pass a 2-FF synchronizer plus rising-edge detector; only edges act; edge is seen 3 clk after the input rises.
REQ-016 Enabled players by {select2,select1}: 00->4 (btn[3:0]), 01->2 (btn[1:0]), 10->3 (btn[2:0]), 11->4; disabled buttons SHALL be ignored everywhere.
REQ-017 FSM states IDLE, ARMED, LOCKED, DONE; encoding is 2-bit binary.
REQ-018 IDLE: answer=0; enabled button edge sets its foul bit; start edge -> ARMED.
REQ-019 Entering ARMED (from any state): getter pulses 1 cycle, answer=0, timer_sec=ANSWER_SEC, second prescaler cleared; foul cleared only when leaving IDLE/DONE is not from a foul in the same cycle.
REQ-020 ARMED: first enabled, non-fouled button edge -> LOCKED, answer=one-hot of that player; simultaneous edges -> lowest index wins.
REQ-021 ARMED: button edge of a player whose foul bit is set SHALL be ignored for that round.
REQ-022 timer_sec SHALL decrement once per CLK_HZ cycles in ARMED and LOCKED; it SHALL not go below 0.
REQ-023 ARMED with timer_sec reaching 0: timeout pulses, -> IDLE, answer=0.
REQ-024 Entering LOCKED: timer_sec reloads ANSWER_SEC, prescaler cleared.
REQ-025 LOCKED: judge_yes edge alone -> Yes pulse, -> DONE; judge_no edge alone -> No pulse, -> DONE; both in same cycle -> both ignored.
REQ-026 LOCKED with timer_sec reaching 0: No pulse, -> DONE (unanswered = wrong).
REQ-027 DONE: answer held, timer_sec frozen; button and judge edges ignored; start edge -> ARMED.
REQ-028 start edge in ARMED or LOCKED SHALL abort and restart the round (REQ-019) with no Yes/No pulse.
REQ-029 Yes, No, getter, timeout SHALL never be high for two consecutive cycles; Yes and No never simultaneously high.
REQ-030 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-031 rst low SHALL asynchronously force: state IDLE, answer=0, getter=0, Yes=0, No=0, timeout=0, timer_sec=0, foul=0, prescaler=0, synchronizer/edge registers 0.
REQ-032 Reset mid-round SHALL discard the round with no Yes/No pulse after release; first edge can be detected no sooner than 3 clk after release.

Structure
REQ-033 State encoding, player-count decode table and one-hot player constants SHALL live in shared package quiz_pkg, also used by the scoring and display stages.
REQ-034 The synchronizer+edge detector SHALL be one sub-module, edge_sync, instantiated per raw input bit.
REQ-035 Second prescaler SHALL be width $clog2(CLK_HZ); test builds use CLK_HZ=10.

Verification (CLK_HZ=10, ANSWER_SEC=3)
REQ-036 start, then btn=0100 -> getter 1 pulse, answer=0100 within 3 clk of press, state LOCKED, timer_sec=3.
REQ-037 ARMED, btn=0110 same cycle -> answer=0010; then judge_yes -> one Yes pulse, answer stays 0010.
REQ-038 btn[0] pressed in IDLE -> foul=0001; start, btn[0] -> ignored; btn[3] -> answer=1000; next start clears foul.
REQ-039 start, no press for 30 clk -> timer_sec 3,2,1,0, timeout 1 pulse, answer=0.
REQ-040 {select2,select1}=01, btn=1000 in ARMED -> ignored; judge_yes+judge_no together in LOCKED -> no pulse.
REQ-041 rst low while LOCKED -> all outputs 0 immediately; after release no Yes/No pulse.
